// File: rtl/fifo2pcie.sv
// FIFO-to-PCIe TX bridge: pops annotated TLP beats from an FWFT FIFO into a 2-entry skid buffer
// feeding the core's 64-bit AXI-stream TX port. Define FIFO2PCIE_LENCHECK_EN for per-TLP length framing.
package fifo2pcie_pkg;

    typedef struct packed {
        logic [1:0]  fmt;
        logic [4:0]  pkttype;
        logic [12:0] len;
        logic [7:0]  tag;
    } tlp_field_t;

    typedef struct packed {
        tlp_field_t  field;
        logic        tvalid;
        logic        tlast;
        logic [7:0]  tkeep;
        logic [63:0] tdata;
        logic [3:0]  tuser;
    } tlp64_t;

    typedef struct packed {
        logic   data_valid;
        tlp64_t tlp;
    } PCIE_FIFO64_TX;

    typedef logic        PCIE_TREADY64;
    typedef logic        PCIE_TVALID64;
    typedef logic        PCIE_TLAST64;
    typedef logic [7:0]  PCIE_TKEEP64;
    typedef logic [63:0] PCIE_TDATA64;
    typedef logic [3:0]  PCIE_TUSER64_TX;

    typedef struct packed {
        logic        tlast;
        logic [7:0]  tkeep;
        logic [63:0] tdata;
        logic [3:0]  tuser;
    } beat_t;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_DRAIN} state_t;

endpackage

module fifo2pcie
    import fifo2pcie_pkg::*;
#(
    parameter logic [5:0] MIN_BUF_AV = 6'd1,
    parameter int         CNT_W      = 32
) (
    input  logic           pcie_clk,
    input  logic           pcie_rst_n,
    output logic           rd_en,
    input  PCIE_FIFO64_TX  dout,
    input  logic           empty,
    input  logic [5:0]     pcie_tx_buf_av,
    input  PCIE_TREADY64   pcie_tready,
    output PCIE_TVALID64   pcie_tvalid,
    output PCIE_TLAST64    pcie_tlast,
    output PCIE_TKEEP64    pcie_tkeep,
    output PCIE_TDATA64    pcie_tdata,
    output PCIE_TUSER64_TX pcie_tuser,
    output logic [CNT_W-1:0] tlp_cnt,
    output logic [15:0]    err_cnt
);

    state_t     state, state_next;
    logic [1:0] occ;
    beat_t      skid [2];
    beat_t      enq_beat;
    logic       permit, pop_valid, push, pop, wr_idx, force_end;

`ifdef FIFO2PCIE_LENCHECK_EN
    logic [10:0] exp_beats, beat_cnt, hdr_exp;
    logic [11:0] cur_exp, cur_beat;
    logic        err_flag;
    logic        unused_fields;
    assign unused_fields = ^{dout.tlp.field.fmt, dout.tlp.field.pkttype,
                             dout.tlp.field.tag, dout.tlp.tvalid};
`else
    logic unused_fields;
    assign unused_fields = ^{dout.tlp.field, dout.tlp.tvalid};
`endif

    always_ff @(posedge pcie_clk) begin
        if (!pcie_rst_n) state <= ST_IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (pop_valid) begin
            case (state)
                ST_IDLE:  if (!dout.tlp.tlast) state_next = ST_DATA;
                ST_DATA:  begin
                    if (dout.tlp.tlast)  state_next = ST_IDLE;
                    else if (force_end)  state_next = ST_DRAIN;
                end
                ST_DRAIN: if (dout.tlp.tlast) state_next = ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        permit    = (state != ST_IDLE) || (pcie_tx_buf_av >= MIN_BUF_AV);
        rd_en     = pcie_rst_n && !empty && (occ != 2'd2) && permit;
        pop_valid = rd_en && dout.data_valid;
        push      = pop_valid && (state != ST_DRAIN);
        enq_beat  = '{tlast: dout.tlp.tlast, tkeep: dout.tlp.tkeep,
                      tdata: dout.tlp.tdata, tuser: dout.tlp.tuser};
        force_end = 1'b0;
`ifdef FIFO2PCIE_LENCHECK_EN
        err_flag  = 1'b0;
        hdr_exp   = 11'(({1'b0, dout.tlp.field.len} + 14'd7) >> 3);
        cur_exp   = (state == ST_IDLE) ? {1'b0, hdr_exp} : {1'b0, exp_beats};
        cur_beat  = (state == ST_IDLE) ? 12'd1 : {1'b0, beat_cnt} + 12'd1;
        // The popped beat is number cur_beat of the TLP; compare against the header's length.
        if (push) begin
            if (dout.tlp.tlast && (cur_beat < cur_exp)) begin
                err_flag          = 1'b1;
                enq_beat.tuser[3] = 1'b1;
            end else if (!dout.tlp.tlast && (state == ST_DATA) && (cur_beat == cur_exp)) begin
                force_end         = 1'b1;
                err_flag          = 1'b1;
                enq_beat.tlast    = 1'b1;
                enq_beat.tuser[3] = 1'b1;
            end
        end
`endif
    end

    assign pop    = pcie_tvalid && pcie_tready;
    assign wr_idx = (occ == 2'd1) && !pop;

    // NOTE: the skid entries are reset because they drive the outputs directly and must read zero.
    always_ff @(posedge pcie_clk) begin
        if (!pcie_rst_n) begin
            occ     <= 2'd0;
            skid[0] <= '0;
            skid[1] <= '0;
            tlp_cnt <= '0;
        end else begin
            if (pop)  skid[0]      <= skid[1];
            if (push) skid[wr_idx] <= enq_beat;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push && enq_beat.tlast) tlp_cnt <= tlp_cnt + CNT_W'(1);
        end
    end

`ifdef FIFO2PCIE_LENCHECK_EN
    always_ff @(posedge pcie_clk) begin
        if (!pcie_rst_n) begin
            exp_beats <= '0;
            beat_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            if (pop_valid && (state == ST_IDLE)) begin
                exp_beats <= hdr_exp;
                beat_cnt  <= 11'd1;
            end else if (pop_valid && (state == ST_DATA)) begin
                beat_cnt  <= beat_cnt + 11'd1;
            end
            if (err_flag && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

    assign pcie_tvalid = (occ != 2'd0);
    assign pcie_tlast  = skid[0].tlast;
    assign pcie_tkeep  = skid[0].tkeep;
    assign pcie_tdata  = skid[0].tdata;
    assign pcie_tuser  = skid[0].tuser;

endmodule

// File: tb/tb_fifo2pcie.sv
// Self-checking bench for fifo2pcie: a TLP-level model predicts the output beat stream and counters,
// checked every accepted beat, plus directed literal expectations.
module tb_fifo2pcie;
    import fifo2pcie_pkg::*;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst_n;
    logic          rd_en;
    PCIE_FIFO64_TX dout;
    logic          empty;
    logic [5:0]    pcie_tx_buf_av;
    logic          pcie_tready;
    logic          pcie_tvalid, pcie_tlast;
    logic [7:0]    pcie_tkeep;
    logic [63:0]   pcie_tdata;
    logic [3:0]    pcie_tuser;
    logic [31:0]   tlp_cnt;
    logic [15:0]   err_cnt;

    always #5 pcie_clk = ~pcie_clk;

    fifo2pcie dut (
        .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .rd_en(rd_en), .dout(dout),
        .empty(empty), .pcie_tx_buf_av(pcie_tx_buf_av), .pcie_tready(pcie_tready),
        .pcie_tvalid(pcie_tvalid), .pcie_tlast(pcie_tlast), .pcie_tkeep(pcie_tkeep),
        .pcie_tdata(pcie_tdata), .pcie_tuser(pcie_tuser), .tlp_cnt(tlp_cnt), .err_cnt(err_cnt)
    );

    int            errors = 0;
    int            checks = 0;
    int            cyc    = 0;
    int            exp_tlp, exp_err;
    logic          rd_en_s = 1'b0;
    PCIE_FIFO64_TX fifo_q[$];
    PCIE_FIFO64_TX tlp_in[$];
    beat_t         exp_q[$];
    int            acc_cyc_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void fifo_refresh();
        if (fifo_q.size() != 0) begin
            dout  = fifo_q[0];
            empty = 1'b0;
        end else begin
            dout  = '0;
            empty = 1'b1;
        end
    endfunction

    function automatic PCIE_FIFO64_TX mk(bit dv, bit last, logic [12:0] len,
                                         logic [63:0] data, logic [3:0] user);
        PCIE_FIFO64_TX e = '0;
        e.data_valid        = dv;
        e.tlp.field.fmt     = 2'b10;
        e.tlp.field.len     = len;
        e.tlp.field.tag     = 8'h11;
        e.tlp.tvalid        = 1'b1;
        e.tlp.tlast         = last;
        e.tlp.tkeep         = last ? 8'h0F : 8'hFF;
        e.tlp.tdata         = data;
        e.tlp.tuser         = user;
        return e;
    endfunction

    // TLP-level model: drop bubbles, number the real beats, apply the length rules.
    function automatic void model_tlp();
        int    k     = 0;
        int    nexp  = 0;
        bit    drain = 1'b0;
        beat_t b;
        foreach (tlp_in[i]) begin
            if (!tlp_in[i].data_valid) continue;
            k++;
            if (k == 1) nexp = (int'(tlp_in[i].tlp.field.len) + 7) / 8;
            if (drain) begin
                if (tlp_in[i].tlp.tlast) drain = 1'b0;
                continue;
            end
            b.tlast = tlp_in[i].tlp.tlast;
            b.tkeep = tlp_in[i].tlp.tkeep;
            b.tdata = tlp_in[i].tlp.tdata;
            b.tuser = tlp_in[i].tlp.tuser;
`ifdef FIFO2PCIE_LENCHECK_EN
            if (b.tlast && k < nexp) begin
                b.tuser[3] = 1'b1;
                exp_err++;
            end else if (!b.tlast && k >= 2 && k == nexp) begin
                b.tlast    = 1'b1;
                b.tuser[3] = 1'b1;
                exp_err++;
                drain      = 1'b1;
            end
`endif
            exp_q.push_back(b);
            if (b.tlast) exp_tlp++;
        end
    endfunction

    task automatic add_tlp(input logic [12:0] len, input int nbeats, input logic [63:0] base,
                           input int bubble_after, input logic [3:0] user);
        for (int i = 0; i < nbeats; i++) begin
            tlp_in.push_back(mk(1'b1, i == nbeats - 1, len, base + 64'(i), user));
            if (i == bubble_after) tlp_in.push_back(mk(1'b0, 1'b1, len, 64'hDEAD_BEEF, 4'hF));
        end
        model_tlp();
        foreach (tlp_in[i]) fifo_q.push_back(tlp_in[i]);
        tlp_in.delete();
        fifo_refresh();
    endtask

    task automatic tick();
        @(posedge pcie_clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !pcie_tvalid) done = 1'b1;
            else tick();
        end
        check({name, "_drained"}, done, 1'b1);
        check({name, "_tlp_cnt_model"}, tlp_cnt, exp_tlp);
        check({name, "_err_cnt_model"}, err_cnt, exp_err);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 200 && acc_cyc_q.size() < n; i++) tick();
        check("acc_wait", acc_cyc_q.size() >= n, 1'b1);
    endtask

    // FIFO model: rd_en sampled at the falling edge, pop applied on the rising edge.
    always @(posedge pcie_clk) begin
        cyc++;
        if (rd_en_s && fifo_q.size() != 0) fifo_q.delete(0);
        #1 fifo_refresh();
    end

    beat_t held, cur;
    bit    held_v = 1'b0;
    always @(negedge pcie_clk) begin
        rd_en_s = rd_en;
        cur     = '{tlast: pcie_tlast, tkeep: pcie_tkeep, tdata: pcie_tdata, tuser: pcie_tuser};
        if (!pcie_rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) check("hold_stable", {pcie_tvalid, cur}, {1'b1, held});
            if (pcie_tvalid && pcie_tready) begin
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("beat_data", cur, exp_q.pop_front());
                acc_cyc_q.push_back(cyc);
            end
            held_v = pcie_tvalid && !pcie_tready;
            held   = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pcie_rst_n     = 1'b0;
        pcie_tready    = 1'b1;
        pcie_tx_buf_av = 6'd8;
        exp_tlp        = 0;
        exp_err        = 0;
        fifo_refresh();
        repeat (3) tick();
        check("rst_tvalid", pcie_tvalid, 1'b0);
        check("rst_tlast", pcie_tlast, 1'b0);
        check("rst_tkeep", pcie_tkeep, 8'h00);
        check("rst_tdata", pcie_tdata, 64'h0);
        check("rst_tuser", pcie_tuser, 4'h0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_tlp_cnt", tlp_cnt, 32'd0);
        check("rst_err_cnt", err_cnt, 16'd0);
        pcie_rst_n = 1'b1;
        tick();

        // 3DW MWr, len 28 -> 4 back-to-back beats
        acc_cyc_q.delete();
        add_tlp(13'd28, 4, 64'h1000, -1, 4'h2);
        wait_drain("t1");
        check("t1_beats", acc_cyc_q.size(), 4);
        if (acc_cyc_q.size() == 4) check("t1_span", acc_cyc_q[3] - acc_cyc_q[0], 3);
        check("t1_tlp_cnt", tlp_cnt, 32'd1);
        check("t1_err_cnt", err_cnt, 16'd0);

        // Same TLP with a bubble between beats 2 and 3
        acc_cyc_q.delete();
        add_tlp(13'd28, 4, 64'h2000, 1, 4'h3);
        wait_drain("t2");
        check("t2_beats", acc_cyc_q.size(), 4);
        check("t2_tlp_cnt", tlp_cnt, 32'd2);

        // Back-pressure for 5 cycles mid-TLP
        acc_cyc_q.delete();
        add_tlp(13'd36, 5, 64'h3000, -1, 4'h5);
        wait_acc(1);
        pcie_tready = 1'b0;
        repeat (5) tick();
        check("stall_rd_en", rd_en, 1'b0);
        check("stall_occ", dut.occ, 2'd2);
        check("stall_tvalid", pcie_tvalid, 1'b1);
        pcie_tready = 1'b1;
        wait_drain("t3");
        check("t3_beats", acc_cyc_q.size(), 5);
        check("t3_tlp_cnt", tlp_cnt, 32'd3);

        // Start gated on buffer availability; a later drop does not stall the TLP
        pcie_tx_buf_av = 6'd0;
        acc_cyc_q.delete();
        add_tlp(13'd16, 2, 64'h4000, -1, 4'h0);
        repeat (3) tick();
        check("bufav_rd_en_low", rd_en, 1'b0);
        check("bufav_tvalid_low", pcie_tvalid, 1'b0);
        pcie_tx_buf_av = 6'd1;
        #1;
        check("bufav_rd_en_high", rd_en, 1'b1);
        tick();
        pcie_tx_buf_av = 6'd0;
        wait_drain("t4");
        check("t4_beats", acc_cyc_q.size(), 2);
        check("t4_tlp_cnt", tlp_cnt, 32'd4);
        pcie_tx_buf_av = 6'd8;

        // len 12 (2 beats expected) but tlast on beat 3
        acc_cyc_q.delete();
        add_tlp(13'd12, 3, 64'h5000, -1, 4'h1);
        wait_drain("t5");
`ifdef FIFO2PCIE_LENCHECK_EN
        check("t5_beats", acc_cyc_q.size(), 2);
        check("t5_err_cnt", err_cnt, 16'd1);
`else
        check("t5_beats", acc_cyc_q.size(), 3);
        check("t5_err_cnt", err_cnt, 16'd0);
`endif
        check("t5_tlp_cnt", tlp_cnt, 32'd5);

        acc_cyc_q.delete();
        add_tlp(13'd28, 4, 64'h6000, -1, 4'h0);
        wait_drain("t6");
        check("t6_beats", acc_cyc_q.size(), 4);
        check("t6_tlp_cnt", tlp_cnt, 32'd6);

        // Reset in the middle of a TLP
        acc_cyc_q.delete();
        add_tlp(13'd36, 5, 64'h7000, -1, 4'h0);
        wait_acc(2);
        pcie_rst_n = 1'b0;
        fifo_q.delete();
        fifo_refresh();
        exp_q.delete();
        exp_tlp = 0;
        exp_err = 0;
        tick();
        check("mrst_tvalid", pcie_tvalid, 1'b0);
        check("mrst_occ", dut.occ, 2'd0);
        check("mrst_tlp_cnt", tlp_cnt, 32'd0);
        check("mrst_err_cnt", err_cnt, 16'd0);
        check("mrst_rd_en", rd_en, 1'b0);
        pcie_rst_n = 1'b1;
        tick();

        acc_cyc_q.delete();
        add_tlp(13'd28, 4, 64'h8000, -1, 4'h6);
        wait_drain("t8");
        check("t8_beats", acc_cyc_q.size(), 4);
        check("t8_tlp_cnt", tlp_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
